// File: rtl/codificador_prioridad_sync_pkg.sv
// Shared types and helpers for the registered priority encoder.
// Encoding helpers work on a 32-bit zero-extended vector so any N_IN up to 32 can reuse them.
package codificador_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    SEND         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int N_IN_DEF   = 4;
  localparam int ENC_MAX_IN = 32;
  localparam int ENC_MAX_W  = 5;

  // Highest set bit wins because later iterations overwrite earlier ones.
  function automatic logic [ENC_MAX_W-1:0] prio_enc(input logic [ENC_MAX_IN-1:0] v);
    logic [ENC_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENC_MAX_IN; i++) begin
      if (v[i]) begin
        idx = ENC_MAX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [ENC_MAX_IN-1:0] v);
    return ((v & (v - 32'd1)) != 32'd0);
  endfunction

endpackage

// File: rtl/codificador_prioridad_sync_sincronizador.sv
// Two-flop synchronizer bank for asynchronous request lines.
module sincronizador #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter: two back-to-back flops per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/codificador_prioridad_sync.sv
// Synchronizing, debouncing priority encoder with valid/ready delivery, one code per press.
// Optional macro MULTI_HOT_DETECT_EN adds multi_o flagging more than one active request.
module codificador_prioridad_sync
  import codificador_pkg::*;
#(
  parameter int N_IN            = N_IN_DEF,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          d_in,
  input  logic                     ready_i,
  output logic [$clog2(N_IN)-1:0]  code_o,
  output logic                     valid_o,
`ifdef MULTI_HOT_DETECT_EN
  output logic                     multi_o,
`endif
  output logic                     busy_o
);

  localparam int W  = $clog2(N_IN);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N_IN-1:0]       sync_s;
  logic [ENC_MAX_IN-1:0] ext_s;
  logic [W-1:0]          enc_s;
  logic                  any_s;

  state_t        state_r, state_nxt;
  logic [W-1:0]  cand_r, cand_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [W-1:0]  code_r, code_nxt;
  logic          valid_r, valid_nxt;
  logic          busy_r, busy_nxt;
`ifdef MULTI_HOT_DETECT_EN
  logic          multi_r, multi_nxt;
`endif

  sincronizador #(.WIDTH(N_IN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d_in),
    .q     (sync_s)
  );

  // Zero-extend synced requests and derive the priority index and activity flag.
  always_comb begin
    ext_s            = '0;
    ext_s[N_IN-1:0]  = sync_s;
    enc_s            = W'(prio_enc(ext_s));
    any_s            = |sync_s;
  end

  // Next-state and output decode for the press/send/release cycle.
  always_comb begin
    state_nxt = state_r;
    cand_nxt  = cand_r;
    cnt_nxt   = cnt_r;
    code_nxt  = code_r;
    valid_nxt = valid_r;
`ifdef MULTI_HOT_DETECT_EN
    multi_nxt = multi_r;
`endif
    case (state_r)
      IDLE: begin
        if (any_s) begin
          cand_nxt  = enc_s;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DEBOUNCE: begin
        if (!any_s || (enc_s != cand_r)) begin
          state_nxt = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          code_nxt  = cand_r;
          valid_nxt = 1'b1;
`ifdef MULTI_HOT_DETECT_EN
          multi_nxt = multi_hot(ext_s);
`endif
          state_nxt = SEND;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      SEND: begin
        // Inputs are deliberately ignored until the consumer takes the code.
        if (valid_r && ready_i) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
`ifdef MULTI_HOT_DETECT_EN
          multi_nxt = 1'b0;
`endif
          state_nxt = WAIT_RELEASE;
        end else begin
          state_nxt = SEND;
        end
      end
      WAIT_RELEASE: begin
        if (any_s) begin
          cnt_nxt = '0;
        end else if (cnt_r == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cand_r  <= '0;
      cnt_r   <= '0;
      code_r  <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
`ifdef MULTI_HOT_DETECT_EN
      multi_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      cand_r  <= cand_nxt;
      cnt_r   <= cnt_nxt;
      code_r  <= code_nxt;
      valid_r <= valid_nxt;
      busy_r  <= busy_nxt;
`ifdef MULTI_HOT_DETECT_EN
      multi_r <= multi_nxt;
`endif
    end
  end

  assign code_o  = code_r;
  assign valid_o = valid_r;
  assign busy_o  = busy_r;
`ifdef MULTI_HOT_DETECT_EN
  assign multi_o = multi_r;
`endif

endmodule

// File: tb/tb_codificador_prioridad_sync.sv
// Directed self-checking bench for codificador_prioridad_sync (default N_IN=4, DEBOUNCE_CYCLES=4).
module tb_codificador_prioridad_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready_i;
  logic [3:0] d_in;
  logic [1:0] code_o;
  logic       valid_o;
  logic       busy_o;
`ifdef MULTI_HOT_DETECT_EN
  logic       multi_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  codificador_prioridad_sync dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (d_in),
    .ready_i (ready_i),
    .code_o  (code_o),
    .valid_o (valid_o),
`ifdef MULTI_HOT_DETECT_EN
    .multi_o (multi_o),
`endif
    .busy_o  (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_inputs();
    d_in = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    d_in    = 4'b0000;
    ready_i = 1'b1;
    repeat (2) tick();
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || code_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b busy=%b code=%0d expected 0 0 0", valid_o, busy_o, code_o);
    end
`ifdef MULTI_HOT_DETECT_EN
    checks++;
    if (multi_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_multi: got %b expected 0", multi_o);
    end
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || code_o !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: valid=%b busy=%b code=%0d expected 0 0 0", k, valid_o, busy_o, code_o);
      end
    end
  endtask

  task automatic test_send_hold();
    logic exp_v;
    ready_i = 1'b0;
    d_in    = 4'b0100;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_v = (k >= 7);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("FAIL hold_valid edge %0d: got %b expected %b", k, valid_o, exp_v);
      end
      if (k >= 7) begin
        checks++;
        if (code_o !== 2'd2 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL hold_code edge %0d: code=%0d busy=%b expected 2 1", k, code_o, busy_o);
        end
      end
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_accept: valid=%b busy=%b expected 0 1", valid_o, busy_o);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_single_transfer cycle %0d: got %b expected 0", k, valid_o);
      end
    end
    release_inputs();
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_idle: busy=%b valid=%b expected 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_priority(input logic [3:0] pattern, input logic [1:0] exp_code, input logic exp_multi);
    logic exp_v;
    ready_i = 1'b1;
    d_in    = pattern;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = (k == 7);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("FAIL prio_valid %b edge %0d: got %b expected %b", pattern, k, valid_o, exp_v);
      end
      if (k == 7) begin
        checks++;
        if (code_o !== exp_code) begin
          errors++;
          $display("FAIL prio_code %b: got %0d expected %0d", pattern, code_o, exp_code);
        end
`ifdef MULTI_HOT_DETECT_EN
        checks++;
        if (multi_o !== exp_multi) begin
          errors++;
          $display("FAIL prio_multi %b: got %b expected %b", pattern, multi_o, exp_multi);
        end
`else
        if (exp_multi === 1'bx) $display("unexpected unknown multi expectation");
`endif
      end
    end
    release_inputs();
  endtask

  task automatic test_glitch();
    ready_i = 1'b1;
    d_in    = 4'b0001;
    repeat (3) tick();
    d_in = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL glitch_valid cycle %0d: got %b expected 0", k, valid_o);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_async_reset();
    logic exp_v;
    ready_i = 1'b0;
    d_in    = 4'b0001;
    repeat (7) tick();
    checks++;
    if (valid_o !== 1'b1 || busy_o !== 1'b1 || code_o !== 2'd0) begin
      errors++;
      $display("FAIL arst_pre: valid=%b busy=%b code=%0d expected 1 1 0", valid_o, busy_o, code_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || code_o !== 2'd0) begin
      errors++;
      $display("FAIL arst_immediate: valid=%b busy=%b code=%0d expected 0 0 0", valid_o, busy_o, code_o);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = (k == 7);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("FAIL arst_repress edge %0d: got %b expected %b", k, valid_o, exp_v);
      end
    end
    checks++;
    if (code_o !== 2'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_repress_code: code=%0d busy=%b expected 0 1", code_o, busy_o);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_accept: got %b expected 0", valid_o);
    end
    release_inputs();
  endtask

  task automatic test_bounce_release();
    logic exp_v;
    ready_i = 1'b1;
    d_in    = 4'b0001;
    repeat (8) tick();
    // Short release followed by a long re-press must not yield a second code.
    d_in = 4'b0000;
    repeat (2) tick();
    d_in = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL bounce_repress cycle %0d: got %b expected 0", k, valid_o);
      end
    end
    d_in = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL bounce_release cycle %0d: got %b expected 0", k, valid_o);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bounce_idle: busy=%b expected 0", busy_o);
    end
    d_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = (k == 7);
      checks++;
      if (valid_o !== exp_v) begin
        errors++;
        $display("FAIL bounce_clean_press edge %0d: got %b expected %b", k, valid_o, exp_v);
      end
    end
    release_inputs();
  endtask

  initial begin
    test_reset();
    test_send_hold();
    test_priority(4'b1010, 2'd3, 1'b1);
    test_priority(4'b0010, 2'd1, 1'b0);
    test_glitch();
    test_async_reset();
    test_bounce_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
